// File: rtl/alu_pkg.sv
// Shared ALU definitions: mode encodings, result payload and default sizing.
package alu_pkg;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SEG   = 8;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] sum;
    logic                 cout;
    logic                 ovf;
    logic                 zero;
  } alu_res_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seg_adder.sv
// Combinational SEG-bit ripple adder built from full_adder cells.
module seg_adder #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic [SEG:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[SEG];

  // Ripple chain: bit i consumes the carry of bit i-1.
  for (genvar i = 0; i < SEG; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: one SEG-bit segment rippled per stage, carry
// registered between stages, whole pipeline freezes on output backpressure.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SEG_SAFE = (SEG == 0) ? 1 : SEG;
  localparam int unsigned NSEG     = WIDTH / SEG_SAFE;

  if ((SEG < 1) || ((WIDTH % SEG_SAFE) != 0)) begin : g_bad_cfg
    $fatal(1, "pipelined_addsub: WIDTH must be a non-zero multiple of SEG");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  logic [WIDTH-1:0] fin_sum_c;
  logic             fin_co_c;
  logic             fin_ovf_c;
  logic             fin_v_c;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  // Whole-pipeline advance; ready depends only on output-side state.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // Subtraction as A + ~B + ~borrow.
  assign b_eff = (sub == ALU_ADD) ? b : ~b;
  assign c0    = (sub == ALU_SUB) ? ~cin : cin;

  // Stage k ripples segment k; non-final stages register the carry, the
  // remaining higher operand segments (skew) and the finished lower sum
  // segments (de-skew).
  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam int unsigned LO = k * SEG;
    localparam int unsigned HI = WIDTH - (k + 1) * SEG;

    logic [SEG-1:0] seg_a;
    logic [SEG-1:0] seg_b;
    logic [SEG-1:0] seg_s;
    logic           seg_ci;
    logic           seg_co;
    logic           vld;

    if (k == 0) begin : g_src
      assign seg_a  = a[SEG-1:0];
      assign seg_b  = b_eff[SEG-1:0];
      assign seg_ci = c0;
      assign vld    = in_valid;
    end else begin : g_src
      assign seg_a  = g_stg[k-1].g_reg.rem_a_q[SEG-1:0];
      assign seg_b  = g_stg[k-1].g_reg.rem_b_q[SEG-1:0];
      assign seg_ci = g_stg[k-1].g_reg.c_q;
      assign vld    = g_stg[k-1].g_reg.v_q;
    end

    seg_adder #(.SEG(SEG)) u_seg (
      .a    (seg_a),
      .b    (seg_b),
      .cin  (seg_ci),
      .sum  (seg_s),
      .cout (seg_co)
    );

    if (k < NSEG - 1) begin : g_reg
      logic [HI-1:0]     rem_a_d;
      logic [HI-1:0]     rem_b_d;
      logic [LO+SEG-1:0] psum_d;
      logic [HI-1:0]     rem_a_q;
      logic [HI-1:0]     rem_b_q;
      logic [LO+SEG-1:0] psum_q;
      logic              c_q;
      logic              v_q;

      if (k == 0) begin : g_nxt
        assign rem_a_d = a[WIDTH-1:SEG];
        assign rem_b_d = b_eff[WIDTH-1:SEG];
        assign psum_d  = seg_s;
      end else begin : g_nxt
        assign rem_a_d = g_stg[k-1].g_reg.rem_a_q[HI+SEG-1:SEG];
        assign rem_b_d = g_stg[k-1].g_reg.rem_b_q[HI+SEG-1:SEG];
        assign psum_d  = {seg_s, g_stg[k-1].g_reg.psum_q};
      end

      // Stage register; frozen while the output is stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rem_a_q <= '0;
          rem_b_q <= '0;
          psum_q  <= '0;
          c_q     <= 1'b0;
          v_q     <= 1'b0;
        end else if (adv) begin
          rem_a_q <= rem_a_d;
          rem_b_q <= rem_b_d;
          psum_q  <= psum_d;
          c_q     <= seg_co;
          v_q     <= vld;
        end
      end
    end else begin : g_last
      if (k == 0) begin : g_cat
        assign fin_sum_c = seg_s;
      end else begin : g_cat
        assign fin_sum_c = {seg_s, g_stg[k-1].g_reg.psum_q};
      end
      assign fin_co_c  = seg_co;
      // Same-sign operands giving an opposite-sign result.
      assign fin_ovf_c = (seg_a[SEG-1] ~^ seg_b[SEG-1]) & (seg_s[SEG-1] ^ seg_a[SEG-1]);
      assign fin_v_c   = vld;
    end
  end

  // Output register holding the assembled result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (adv) begin
      out_valid_q <= fin_v_c;
      sum_q       <= fin_sum_c;
      cout_q      <= fin_co_c;
      ovf_q       <= fin_ovf_c;
      zero_q      <= (fin_sum_c == '0);
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
